lsu_mmio: RTL and testbench



---
 rtl/lsu_mmio.sv | 164 ++++++++++++++++
 tb/tb_lsu_mmio.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mmio.sv
// rtl/lsu_mmio.sv - load-store unit with data memory and memory-mapped peripherals
module lsu_mmio #(
    parameter int DMEM_WORDS = 256,
    parameter int NUM_HEX    = 8,
    parameter int SW_W       = 18
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [11:0]            req_addr_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_unsigned_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    input  logic [SW_W-1:0]        io_sw_i,
    output logic [NUM_HEX*32-1:0]  io_hex_o,
    output logic [31:0]            io_ledr_o,
    output logic [31:0]            io_ledg_o,
    output logic [31:0]            io_lcd_o
);

    localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t state_q, state_d;

    logic [31:0]     mem [DMEM_WORDS];
    logic [31:0]     hex_q [NUM_HEX];
    logic [SW_W-1:0] sw_s1, sw_s2;

    logic            accept;
    logic            hit_dmem, hit_hex, hit_ledr, hit_ledg, hit_lcd, hit_sw, hit_periph;
    logic            err_c, do_store;
    logic [2:0]      hex_idx;
    logic [AW-1:0]   midx;
    logic [31:0]     rword, sh, ld;
    logic [3:0]      be;
    logic [31:0]     wlane;

    assign accept  = req_valid_i && req_ready_o;
    assign hex_idx = req_addr_i[6:4];
    assign midx    = req_addr_i[AW+1:2];

    // Address decode and fault detection; peripherals match on the whole word address.
    always_comb begin
        hit_dmem   = {1'b0, req_addr_i} < 13'(4 * DMEM_WORDS);
        hit_hex    = (req_addr_i[11:7] == 5'b01000) && (req_addr_i[3:2] == 2'b00)
                     && (int'(hex_idx) < NUM_HEX);
        hit_ledr   = (req_addr_i[11:2] == 10'h120);
        hit_ledg   = (req_addr_i[11:2] == 10'h124);
        hit_lcd    = (req_addr_i[11:2] == 10'h128);
        hit_sw     = (req_addr_i[11:2] == 10'h140);
        hit_periph = hit_hex || hit_ledr || hit_ledg || hit_lcd || hit_sw;
        err_c      = (req_size_i == 2'b11)
                     || (req_size_i == 2'b01 && req_addr_i[0])
                     || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00)
                     || !(hit_dmem || hit_periph)
                     || (req_we_i && hit_sw)
                     || (hit_periph && req_size_i != 2'b10);
        do_store   = accept && req_we_i && !err_c;
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be    = 4'b0000;
        wlane = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                be    = 4'b0001 << req_addr_i[1:0];
                wlane = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req_wdata_i[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Read-word select, lane shift and sign/zero extension for loads.
    always_comb begin
        rword = 32'h0;
        if (hit_dmem)      rword = mem[midx];
        else if (hit_hex)  rword = hex_q[hex_idx];
        else if (hit_ledr) rword = io_ledr_o;
        else if (hit_ledg) rword = io_ledg_o;
        else if (hit_lcd)  rword = io_lcd_o;
        else if (hit_sw)   rword = 32'(sw_s2);
        sh = rword >> {req_addr_i[1:0], 3'b000};
        case (req_size_i)
            2'b00:   ld = req_unsigned_i ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ld = req_unsigned_i ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ld = sh;
        endcase
    end

    // Data memory: byte-lane writes at the accept edge, contents never reset.
    always_ff @(posedge clk_i) begin
        if (do_store && hit_dmem) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[midx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    // Output peripheral registers and the two-flop switch synchroniser.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= 32'h0;
            io_ledr_o <= 32'h0;
            io_ledg_o <= 32'h0;
            io_lcd_o  <= 32'h0;
            sw_s1     <= '0;
            sw_s2     <= '0;
        end else begin
            sw_s1 <= io_sw_i;
            sw_s2 <= sw_s1;
            if (do_store) begin
                if (hit_hex)  hex_q[hex_idx] <= req_wdata_i;
                if (hit_ledr) io_ledr_o <= req_wdata_i;
                if (hit_ledg) io_ledg_o <= req_wdata_i;
                if (hit_lcd)  io_lcd_o  <= req_wdata_i;
            end
        end
    end

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
        assign io_hex_o[32*g +: 32] = hex_q[g];
    end

    // Response payload, captured on accept and held until replaced.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else if (accept) begin
            rsp_err_o   <= err_c;
            rsp_rdata_o <= (err_c || req_we_i) ? 32'h0 : ld;
        end
    end

    // Handshake FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs; ready is held low during reset.
    always_comb begin
        state_d     = state_q;
        req_ready_o = !rst_i && ((state_q == IDLE) || rsp_ready_i);
        rsp_valid_o = (state_q == RESP);
        if (accept)                         state_d = RESP;
        else if (state_q == RESP && rsp_ready_i) state_d = IDLE;
    end

endmodule

// File: tb/tb_lsu_mmio.sv
// tb/tb_lsu_mmio.sv - scoreboard bench for lsu_mmio
module tb_lsu_mmio;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         req_we_i;
    logic [11:0]  req_addr_i;
    logic [1:0]   req_size_i;
    logic         req_unsigned_i;
    logic [31:0]  req_wdata_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [31:0]  rsp_rdata_o;
    logic         rsp_err_o;
    logic [17:0]  io_sw_i;
    logic [255:0] io_hex_o;
    logic [31:0]  io_ledr_o, io_ledg_o, io_lcd_o;

    always #5 clk_i = ~clk_i;

    lsu_mmio #(.DMEM_WORDS(256), .NUM_HEX(8), .SW_W(18)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .io_sw_i(io_sw_i), .io_hex_o(io_hex_o), .io_ledr_o(io_ledr_o),
        .io_ledg_o(io_ledg_o), .io_lcd_o(io_lcd_o)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] sbq [$];
    logic [7:0]  bm [0:1023];
    int          cyc = 0;
    int          last_pop = -10;
    int          run_len = 0;
    int          max_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_load(input logic [11:0] a, input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        int          ai;
        ai = int'(a);
        case (sz)
            2'd0:    v = uns ? {24'h0, bm[ai]} : {{24{bm[ai][7]}}, bm[ai]};
            2'd1:    v = uns ? {16'h0, bm[ai+1], bm[ai]} : {{16{bm[ai+1][7]}}, bm[ai+1], bm[ai]};
            default: v = {bm[ai+3], bm[ai+2], bm[ai+1], bm[ai]};
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int ai;
        ai = int'(a);
        bm[ai] = wd[7:0];
        if (sz != 2'd0) bm[ai+1] = wd[15:8];
        if (sz == 2'd2) begin
            bm[ai+2] = wd[23:16];
            bm[ai+3] = wd[31:24];
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input bit we, input logic [11:0] a, input logic [1:0] sz, input bit uns,
                         input logic [31:0] wd, input bit eerr, input logic [31:0] erd);
        bit got_ready;
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = a;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_wdata_i    = wd;
        got_ready      = 1'b0;
        for (int i = 0; i < 50 && !got_ready; i++) begin
            @(negedge clk_i);
            if (req_ready_o) got_ready = 1'b1;
            else begin
                @(posedge clk_i);
                #1;
            end
        end
        if (!got_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            sbq.push_back({eerr, erd});
            if (we && !eerr && a < 12'h400) model_store(a, sz, wd);
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
            @(posedge clk_i);
            #1;
        end
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    initial forever @(posedge clk_i) cyc++;

    // Response monitor: every completed response handshake pops one expectation.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk_i);
            if (rsp_valid_o && rsp_ready_i) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_err", {31'h0, rsp_err_o}, {31'h0, e[32]});
                    check("rsp_rdata", rsp_rdata_o, e[31:0]);
                end
                run_len  = (cyc == last_pop + 1) ? run_len + 1 : 1;
                last_pop = cyc;
                if (run_len > max_run) max_run = run_len;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] a;
        logic [1:0]  sz;
        bit          uns;
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_size_i = '0;
        req_unsigned_i = 1'b0; req_wdata_i = '0; rsp_ready_i = 1'b1; io_sw_i = '0;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", {31'h0, req_ready_o}, 32'd0);
        check("rst_valid", {31'h0, rsp_valid_o}, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_err", {31'h0, rsp_err_o}, 32'd0);
        check("rst_hex", {31'h0, |io_hex_o}, 32'd0);
        check("rst_leds", io_ledr_o | io_ledg_o | io_lcd_o, 32'd0);
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready", {31'h0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;

        // Stores into lanes, then loads with extension
        issue(1, 12'h010, 2'd2, 0, 32'hDEADBEEF, 0, 32'h0);
        issue(1, 12'h012, 2'd0, 0, 32'h00000055, 0, 32'h0);
        issue(0, 12'h010, 2'd2, 0, 32'h0, 0, 32'hDE55BEEF);
        @(negedge clk_i);
        check("lat1_valid", {31'h0, rsp_valid_o}, 32'd1);
        check("lat1_rdata", rsp_rdata_o, 32'hDE55BEEF);
        @(posedge clk_i); #1;
        issue(0, 12'h013, 2'd0, 0, 32'h0, 0, 32'hFFFFFFDE);
        issue(0, 12'h013, 2'd0, 1, 32'h0, 0, 32'h000000DE);
        issue(0, 12'h012, 2'd1, 0, 32'h0, 0, 32'hFFFFDE55);
        issue(0, 12'h012, 2'd1, 1, 32'h0, 0, 32'h0000DE55);

        // Peripheral registers
        issue(1, 12'h430, 2'd2, 0, 32'h0000003F, 0, 32'h0);
        @(negedge clk_i);
        check("hex3_out", io_hex_o[127:96], 32'h0000003F);
        check("hex_other", {31'h0, |{io_hex_o[255:128], io_hex_o[95:0]}}, 32'd0);
        @(posedge clk_i); #1;
        issue(0, 12'h430, 2'd2, 0, 32'h0, 0, 32'h0000003F);
        issue(1, 12'h480, 2'd2, 0, 32'h12345678, 0, 32'h0);
        issue(1, 12'h480, 2'd0, 0, 32'h000000FF, 1, 32'h0);
        @(negedge clk_i);
        check("ledr_keep", io_ledr_o, 32'h12345678);
        @(posedge clk_i); #1;

        // Switch synchroniser
        io_sw_i = 18'h2A5A5;
        repeat (2) @(posedge clk_i);
        #1;
        issue(0, 12'h500, 2'd2, 0, 32'h0, 0, 32'h0002A5A5);
        issue(1, 12'h500, 2'd2, 0, 32'h1, 1, 32'h0);

        // Faulting accesses leave memory untouched
        issue(1, 12'h004, 2'd2, 0, 32'h11223344, 0, 32'h0);
        issue(0, 12'h011, 2'd1, 0, 32'h0, 1, 32'h0);
        issue(1, 12'h006, 2'd2, 0, 32'hFFFFFFFF, 1, 32'h0);
        issue(0, 12'h600, 2'd2, 0, 32'h0, 1, 32'h0);
        issue(1, 12'h010, 2'd3, 0, 32'h0, 1, 32'h0);
        issue(0, 12'h010, 2'd3, 0, 32'h0, 1, 32'h0);
        issue(0, 12'h004, 2'd2, 0, 32'h0, 0, 32'h11223344);
        issue(0, 12'h010, 2'd2, 0, 32'h0, 0, 32'hDE55BEEF);

        // Random word stores and mixed-size loads checked against the byte model
        for (int i = 0; i < 8; i++)
            issue(1, 12'h100 + 12'(4 * i), 2'd2, 0, $urandom, 0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            a   = 12'h100 + 12'($urandom_range(0, 31));
            sz  = 2'($urandom_range(0, 2));
            uns = 1'($urandom_range(0, 1));
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            issue(0, a, sz, uns, 32'h0, 0, exp_load(a, sz, uns));
        end
        wait_drain();

        // Backpressure holds the response
        rsp_ready_i = 1'b0;
        issue(0, 12'h010, 2'd2, 0, 32'h0, 0, 32'hDE55BEEF);
        repeat (3) begin
            @(negedge clk_i);
            check("stall_ready", {31'h0, req_ready_o}, 32'd0);
            check("stall_valid", {31'h0, rsp_valid_o}, 32'd1);
            check("stall_rdata", rsp_rdata_o, 32'hDE55BEEF);
        end
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Four back-to-back loads
        run_len = 0; max_run = 0; last_pop = -10;
        for (int i = 0; i < 4; i++)
            issue(0, 12'h100 + 12'(4 * i), 2'd2, 0, 32'h0, 0, exp_load(12'h100 + 12'(4 * i), 2'd2, 0));
        wait_drain();
        check("b2b_run", 32'(max_run), 32'd4);

        // Reset mid-stream drops the pending response and the concurrent store
        issue(1, 12'h490, 2'd2, 0, 32'h000000A5, 0, 32'h0);
        issue(1, 12'h4A0, 2'd2, 0, 32'h00000077, 0, 32'h0);
        wait_drain();
        rsp_ready_i = 1'b0;
        issue(0, 12'h100, 2'd2, 0, 32'h0, 0, exp_load(12'h100, 2'd2, 0));
        rst_i = 1'b1;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 12'h100; req_size_i = 2'd2;
        req_wdata_i = 32'hCAFEF00D;
        @(negedge clk_i);
        check("rst_mid_ready", {31'h0, req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_valid", {31'h0, rsp_valid_o}, 32'd0);
        check("rst_mid_hex", {31'h0, |io_hex_o}, 32'd0);
        check("rst_mid_leds", io_ledr_o | io_ledg_o | io_lcd_o, 32'd0);
        sbq.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_ready_after", {31'h0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        issue(0, 12'h100, 2'd2, 0, 32'h0, 0, exp_load(12'h100, 2'd2, 0));
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
